dma_pingpong_ctrl: RTL

//  Sequencer for the DMA ping-pong byte buffers (two banks, DEPTH bytes each).

---
 rtl/dma_pingpong_if.sv | 38 +++
 rtl/dma_pingpong_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dma_pingpong_if.sv
// Handshake and bank-steering bundle between the ping-pong DMA sequencer and its environment.
interface dma_pingpong_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LEN_W = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             start;
  logic             mode;
  logic [LEN_W-1:0] xfer_len;
  logic             abort;
  logic             src_valid;
  logic             src_ready;
  logic             snk_valid;
  logic             snk_ready;
  logic             wr_bank;
  logic [AW-1:0]    wr_addr;
  logic             wr_half;
  logic             wr_en;
  logic             rd_bank;
  logic [AW-1:0]    rd_addr;
  logic             rd_half;
  logic             busy;
  logic             done;
  logic             aborted;

  modport master (
    output start, mode, xfer_len, abort, src_valid, snk_ready,
    input  src_ready, snk_valid, wr_bank, wr_addr, wr_half, wr_en,
           rd_bank, rd_addr, rd_half, busy, done, aborted
  );

  modport slave (
    input  start, mode, xfer_len, abort, src_valid, snk_ready,
    output src_ready, snk_valid, wr_bank, wr_addr, wr_half, wr_en,
           rd_bank, rd_addr, rd_half, busy, done, aborted
  );
endinterface

// File: rtl/dma_pingpong_ctrl.sv
// Ping-pong bank sequencer: fills one byte bank from the source while the other drains to the sink,
// with 8/4-bit width conversion handled as nibble beat counting (low nibble first).
module dma_pingpong_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LEN_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  dma_pingpong_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state, state_n;
  logic             mode_q;
  logic [LEN_W-1:0] wr_left, rd_left;
  logic [1:0]       full;
  logic [CW-1:0]    cnt [2];
  logic             wr_bank, rd_bank, wr_half, rd_half;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic             busy_q, done_q, aborted_q;

  logic src_ready_c, snk_valid_c, wr_fire, rd_fire, wr_byte, rd_byte;
  logic wr_seal, rd_drain, rd_last, take_start, take_abort;

  // Handshake qualification and next-state decode; abort masks both handshakes.
  always_comb begin
    state_n     = state;
    src_ready_c = 1'b0;
    snk_valid_c = 1'b0;
    take_start  = (state == IDLE) && bus.start;
    take_abort  = (state != IDLE) && bus.abort;
    if (state == RUN && !bus.abort) begin
      src_ready_c = !full[wr_bank] && (wr_left != '0);
      snk_valid_c = full[rd_bank];
    end
    wr_fire  = src_ready_c && bus.src_valid;
    rd_fire  = snk_valid_c && bus.snk_ready;
    // mode=1: source is byte-wide, sink is nibble-wide; mode=0 the reverse
    wr_byte  = wr_fire && (mode_q || wr_half);
    rd_byte  = rd_fire && (!mode_q || rd_half);
    wr_seal  = wr_byte && ((wr_addr == AW'(DEPTH - 1)) || (wr_left == LEN_W'(1)));
    rd_drain = rd_byte && ((CW'(rd_addr) + CW'(1)) == cnt[rd_bank]);
    rd_last  = rd_byte && (rd_left == LEN_W'(1));
    case (state)
      IDLE:    if (bus.start) state_n = (bus.xfer_len != '0) ? RUN : FINISH;
      RUN:     if (bus.abort) state_n = IDLE;
               else if (rd_last) state_n = FINISH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Bank flags, addresses and byte counters; reset and abort share the same clearing.
  always_ff @(posedge clk) begin
    if (reset || take_abort) begin
      mode_q    <= 1'b0;
      wr_left   <= '0;
      rd_left   <= '0;
      full      <= '0;
      cnt[0]    <= '0;
      cnt[1]    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      wr_half   <= 1'b0;
      rd_half   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= !reset;
    end else begin
      busy_q    <= (state_n != IDLE);
      done_q    <= (state == FINISH);
      aborted_q <= 1'b0;
      if (take_start) begin
        mode_q  <= bus.mode;
        wr_left <= bus.xfer_len;
        rd_left <= bus.xfer_len;
        full    <= '0;
        wr_bank <= 1'b0;
        rd_bank <= 1'b0;
        wr_addr <= '0;
        rd_addr <= '0;
        wr_half <= 1'b0;
        rd_half <= 1'b0;
      end else begin
        if (wr_fire) begin
          if (!wr_byte) begin
            wr_half <= 1'b1;
          end else begin
            wr_half <= 1'b0;
            wr_left <= wr_left - LEN_W'(1);
            if (wr_seal) begin
              full[wr_bank] <= 1'b1;
              cnt[wr_bank]  <= CW'(wr_addr) + CW'(1);
              wr_addr       <= '0;
              wr_bank       <= ~wr_bank;
            end else begin
              wr_addr <= wr_addr + AW'(1);
            end
          end
        end
        if (rd_fire) begin
          if (!rd_byte) begin
            rd_half <= 1'b1;
          end else begin
            rd_half <= 1'b0;
            rd_left <= rd_left - LEN_W'(1);
            if (rd_drain) begin
              full[rd_bank] <= 1'b0;
              rd_addr       <= '0;
              rd_bank       <= ~rd_bank;
            end else begin
              rd_addr <= rd_addr + AW'(1);
            end
          end
        end
      end
    end
  end

  assign bus.src_ready = src_ready_c;
  assign bus.snk_valid = snk_valid_c;
  assign bus.wr_en     = wr_fire;
  assign bus.wr_bank   = wr_bank;
  assign bus.wr_addr   = wr_addr;
  assign bus.wr_half   = wr_half;
  assign bus.rd_bank   = rd_bank;
  assign bus.rd_addr   = rd_addr;
  assign bus.rd_half   = rd_half;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
endmodule
